// File: rtl/test_monitor_pkg.sv
// -----------------------------------------------------------------------------
// test_monitor_pkg
// Shared types for the test signature monitor.
//   mon_state_t        : monitor FSM states (IDLE, RUN, PASS, FAIL)
//   first_bad_width()  : width needed to encode channel indices 0..NCH, where
//                        the value NCH means "every channel matched"
// -----------------------------------------------------------------------------
package test_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } mon_state_t;

  function automatic int first_bad_width(input int nch);
    return $clog2(nch + 1);
  endfunction

endpackage

// File: rtl/monitor_channel.sv
// -----------------------------------------------------------------------------
// monitor_channel
// One signature check channel. Snoops bus writes while the monitor is running
// and remembers whether the most recent write to its address carried the
// expected value.
// Ports:
//   clk_i, reset_i            : clock, synchronous active-high reset
//   clear_i                   : run is starting, forget any previous result
//   run_i                     : monitor is in RUN, writes are observed
//   write_en_i, address_i,
//   data_i                    : snooped CPU write
//   check_addr_i, check_data_i: location watched and value expected there
//   match_d_o                 : next-state match flag (for end-of-test logic)
//   match_q_o                 : registered match flag
// -----------------------------------------------------------------------------
module monitor_channel #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              run_i,
  input  logic              write_en_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] check_addr_i,
  input  logic [DATA_W-1:0] check_data_i,
  output logic              match_d_o,
  output logic              match_q_o
);

  logic match_q, match_d;

  // NOTE: assign a default first so every path through the block drives
  // match_d; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    match_d = match_q;
    if (clear_i) begin
      match_d = 1'b0;
    end else if (run_i && write_en_i && (address_i == check_addr_i)) begin
      // Last write wins: a later correct write repairs an earlier mismatch.
      match_d = (data_i == check_data_i);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match_d_o = match_d;
  assign match_q_o = match_q;

endmodule

// File: rtl/test_signature_monitor.sv
// -----------------------------------------------------------------------------
// test_signature_monitor
// Self-checking bus monitor for ROM-based test suites. After a start pulse it
// watches CPU writes to NCH signature locations and ends with PASS once all
// of them hold their expected value, or with FAIL on an end-of-test write
// with missing signatures or on a cycle timeout.
// Ports:
//   ph1, reset            : clock, synchronous active-high reset
//   start                 : one-cycle pulse begins a run (ignored while busy)
//   write_en, address,
//   data_out              : snooped CPU write bus
//   check_addr/check_data : per-channel packed address / expected data
//   busy, pass, fail      : current monitor state
//   timed_out             : last run ended by the cycle timeout
//   chan_match            : per-channel "last write matched"
//   first_bad             : lowest unmatched channel, NCH when all matched
//   cycle_count           : RUN cycles elapsed, frozen once the run ends
// -----------------------------------------------------------------------------
module test_signature_monitor
  import test_monitor_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 8,
  parameter int                NCH      = 4,
  parameter int                TIMEOUT  = 4096,
  parameter logic [ADDR_W-1:0] END_ADDR = 16'hFFF0,
  parameter int                CNT_W    = 16,
  localparam int               FB_W     = first_bad_width(NCH)
) (
  input  logic                  ph1,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  write_en,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data_out,
  input  logic [NCH*ADDR_W-1:0] check_addr,
  input  logic [NCH*DATA_W-1:0] check_data,
  output logic                  busy,
  output logic                  pass,
  output logic                  fail,
  output logic                  timed_out,
  output logic [NCH-1:0]        chan_match,
  output logic [FB_W-1:0]       first_bad,
  output logic [CNT_W-1:0]      cycle_count
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  mon_state_t       state_q, state_d;
  logic             timed_out_q, timed_out_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d, count_inc;
  logic [FB_W-1:0]  first_bad_q, first_bad_d;
  logic [NCH-1:0]   chan_match_q, chan_match_d;
  logic             running, start_ok, all_match, end_write;

  assign running   = (state_q == RUN);
  assign start_ok  = start && !running;
  assign all_match = &chan_match_d;
  assign end_write = write_en && (address == END_ADDR);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    monitor_channel #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_chan (
      .clk_i        (ph1),
      .reset_i      (reset),
      .clear_i      (start_ok),
      .run_i        (running),
      .write_en_i   (write_en),
      .address_i    (address),
      .data_i       (data_out),
      .check_addr_i (check_addr[i*ADDR_W +: ADDR_W]),
      .check_data_i (check_data[i*DATA_W +: DATA_W]),
      .match_d_o    (chan_match_d[i]),
      .match_q_o    (chan_match_q[i])
    );
  end

  assign count_inc = (cycle_count_q >= TIMEOUT_C) ? TIMEOUT_C
                                                  : cycle_count_q + CNT_W'(1);

  // End conditions look at next-state matches so the write that completes
  // the signature set ends the run in the same cycle. A full match beats a
  // simultaneous timeout.
  always_comb begin
    state_d       = state_q;
    timed_out_d   = timed_out_q;
    cycle_count_d = cycle_count_q;
    case (state_q)
      RUN: begin
        cycle_count_d = count_inc;
        if (all_match) begin
          state_d = PASS;
        end else if (end_write) begin
          state_d = FAIL;
        end else if (count_inc == TIMEOUT_C) begin
          state_d     = FAIL;
          timed_out_d = 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d       = RUN;
          timed_out_d   = 1'b0;
          cycle_count_d = '0;
        end
      end
    endcase
  end

  // Lowest-index priority: scanning downward lets the smallest unmatched
  // index overwrite any larger one.
  always_comb begin
    first_bad_d = FB_W'(NCH);
    for (int i = NCH - 1; i >= 0; i--) begin
      if (!chan_match_d[i]) first_bad_d = FB_W'(i);
    end
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q       <= IDLE;
      timed_out_q   <= 1'b0;
      cycle_count_q <= '0;
      first_bad_q   <= '0;
    end else begin
      state_q       <= state_d;
      timed_out_q   <= timed_out_d;
      cycle_count_q <= cycle_count_d;
      first_bad_q   <= first_bad_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign pass        = (state_q == PASS);
  assign fail        = (state_q == FAIL);
  assign timed_out   = timed_out_q;
  assign chan_match  = chan_match_q;
  assign first_bad   = first_bad_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_test_signature_monitor.sv
// -----------------------------------------------------------------------------
// tb_test_signature_monitor
// Bench for test_signature_monitor with NCH=2, TIMEOUT=50,
// ch0 = 0x0042 / 0xCF, ch1 = 0x0043 / 0x01.
// -----------------------------------------------------------------------------
module tb_test_signature_monitor;

  localparam int              ADDR_W   = 16;
  localparam int              DATA_W   = 8;
  localparam int              NCH      = 2;
  localparam int              TIMEOUT  = 50;
  localparam int              CNT_W    = 16;
  localparam logic [15:0]     END_ADDR = 16'hFFF0;
  localparam logic [15:0]     A0 = 16'h0042, A1 = 16'h0043;
  localparam logic [7:0]      D0 = 8'hCF,    D1 = 8'h01;

  logic                  ph1 = 1'b0;
  logic                  reset, start, write_en;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     data_out;
  logic [NCH*ADDR_W-1:0] check_addr;
  logic [NCH*DATA_W-1:0] check_data;
  logic                  busy, pass, fail, timed_out;
  logic [NCH-1:0]        chan_match;
  logic [1:0]            first_bad;
  logic [CNT_W-1:0]      cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  assign check_addr = {A1, A0};
  assign check_data = {D1, D0};

  always #5 ph1 = ~ph1;

  test_signature_monitor #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NCH      (NCH),
    .TIMEOUT  (TIMEOUT),
    .END_ADDR (END_ADDR),
    .CNT_W    (CNT_W)
  ) dut (
    .ph1         (ph1),
    .reset       (reset),
    .start       (start),
    .write_en    (write_en),
    .address     (address),
    .data_out    (data_out),
    .check_addr  (check_addr),
    .check_data  (check_data),
    .busy        (busy),
    .pass        (pass),
    .fail        (fail),
    .timed_out   (timed_out),
    .chan_match  (chan_match),
    .first_bad   (first_bad),
    .cycle_count (cycle_count)
  );

  // Observation word: {pad, busy, pass, fail, timed_out, match[1:0], fb[1:0], count}
  function automatic logic [31:0] pack(input logic b, input logic p, input logic f,
                                       input logic t, input logic [1:0] m,
                                       input logic [1:0] fb, input logic [15:0] c);
    return {8'h00, b, p, f, t, m, fb, c};
  endfunction

  function automatic logic [31:0] obs();
    return pack(busy, pass, fail, timed_out, chan_match, first_bad, cycle_count);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (busy,pass,fail,to,match,fb,count)",
               name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle before sampling.
  task automatic apply(input logic r, input logic s, input logic we,
                       input logic [15:0] a, input logic [7:0] d);
    reset = r; start = s; write_en = we; address = a; data_out = d;
    @(posedge ph1);
    #1;
  endtask

  typedef struct {
    logic        rst, st, we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        b, p, f, t;
    logic [1:0]  m, fb;
    logic [15:0] c;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic st, input logic we,
                     input logic [15:0] a, input logic [7:0] d,
                     input logic b, input logic p, input logic f, input logic t,
                     input logic [1:0] m, input logic [1:0] fb, input logic [15:0] c);
    vec_t v;
    v.rst = rst; v.st = st; v.we = we; v.addr = a; v.data = d;
    v.b = b; v.p = p; v.f = f; v.t = t; v.m = m; v.fb = fb; v.c = c;
    vq.push_back(v);
  endtask

  // Behavioural reference: transaction-level bookkeeping of one run.
  bit       m_busy, m_pass, m_fail, m_to;
  bit [1:0] m_match;
  int       m_cnt;

  function automatic logic [1:0] model_first_bad(input bit [1:0] m);
    for (int i = 0; i < NCH; i++) if (!m[i]) return 2'(i);
    return 2'(NCH);
  endfunction

  task automatic model_step(input logic r, input logic s, input logic we,
                            input logic [15:0] a, input logic [7:0] d);
    if (r) begin
      m_busy = 0; m_pass = 0; m_fail = 0; m_to = 0; m_match = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (s) begin
        m_busy = 1; m_pass = 0; m_fail = 0; m_to = 0; m_match = 0; m_cnt = 0;
      end
    end else begin
      if (we && a == A0) m_match[0] = (d == D0);
      if (we && a == A1) m_match[1] = (d == D1);
      if (m_cnt < TIMEOUT) m_cnt = m_cnt + 1;
      if (m_match == 2'b11) begin
        m_busy = 0; m_pass = 1;
      end else if (we && a == END_ADDR) begin
        m_busy = 0; m_fail = 1;
      end else if (m_cnt == TIMEOUT) begin
        m_busy = 0; m_fail = 1; m_to = 1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; write_en = 1'b0; address = '0; data_out = '0;

    //   rst   st    we    addr   data   busy  pass  fail  to    match  fb    count
    add(1'b1, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0);
    // Straight pass
    add(1'b0, 1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0);
    add(1'b0, 1'b0, 1'b1, A0,    D0,    1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'd1, 16'd1);
    add(1'b0, 1'b0, 1'b1, A1,    D1,    1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'd2, 16'd2);
    add(1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'd2, 16'd2);
    // Mismatch then end-of-test write
    add(1'b0, 1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0);
    add(1'b0, 1'b0, 1'b1, A0,    8'hCE, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd1);
    add(1'b0, 1'b0, 1'b1, END_ADDR, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 16'd2);
    add(1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 16'd2);
    // Last write wins
    add(1'b0, 1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0);
    add(1'b0, 1'b0, 1'b1, A0,    8'hCE, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd1);
    add(1'b0, 1'b0, 1'b1, A0,    D0,    1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'd1, 16'd2);
    add(1'b0, 1'b0, 1'b1, A1,    D1,    1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'd2, 16'd3);
    // Write outside RUN ignored; start in RUN ignored; match can be lost again
    add(1'b0, 1'b0, 1'b1, A0,    8'hCE, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'd2, 16'd3);
    add(1'b0, 1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0);
    add(1'b0, 1'b0, 1'b1, A1,    D1,    1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'd0, 16'd1);
    add(1'b0, 1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'd0, 16'd2);
    add(1'b0, 1'b0, 1'b1, A1,    8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd3);
    // Reset mid-run, then writes ignored until a new start
    add(1'b1, 1'b0, 1'b1, A0,    D0,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0);
    add(1'b0, 1'b0, 1'b1, A0,    D0,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0);
    add(1'b0, 1'b0, 1'b1, A1,    D1,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0);

    foreach (vq[i]) begin
      apply(vq[i].rst, vq[i].st, vq[i].we, vq[i].addr, vq[i].data);
      check($sformatf("vec%0d", i), obs(),
            pack(vq[i].b, vq[i].p, vq[i].f, vq[i].t, vq[i].m, vq[i].fb, vq[i].c));
    end

    // Timeout with only channel 0 matched
    apply(1'b0, 1'b1, 1'b0, 16'h0, 8'h00);
    check("to_start", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0));
    apply(1'b0, 1'b0, 1'b1, A0, D0);
    check("to_c1", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'd1, 16'd1));
    for (int k = 2; k < TIMEOUT; k++) begin
      apply(1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
      check("to_run", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'd1, 16'(k)));
    end
    apply(1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    check("to_end", obs(), pack(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'd1, 16'd50));
    apply(1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    check("to_hold", obs(), pack(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'd1, 16'd50));
    apply(1'b0, 1'b1, 1'b0, 16'h0, 8'h00);
    check("to_clear", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 16'd0));

    // Completing match on the very last RUN cycle wins over the timeout
    apply(1'b0, 1'b0, 1'b1, A0, D0);
    for (int k = 2; k < TIMEOUT; k++) apply(1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    check("edge_c49", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'd1, 16'd49));
    apply(1'b0, 1'b0, 1'b1, A1, D1);
    check("edge_pass", obs(), pack(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'd2, 16'd50));

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      logic        r, s, we;
      logic [15:0] a;
      logic [7:0]  d;
      int          sel;
      r   = (n == 0) || ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 19) == 0);
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = A0;
      else if (sel < 8)  a = A1;
      else if (sel == 8) a = END_ADDR;
      else               a = 16'($urandom);
      if ($urandom_range(0, 1) == 1) d = (a == A0) ? D0 : D1;
      else                           d = 8'($urandom);
      apply(r, s, we, a, d);
      model_step(r, s, we, a, d);
      check("rand", obs(), pack(m_busy, m_pass, m_fail, m_to, m_match,
                                model_first_bad(m_match), 16'(m_cnt)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
